seq_capture_ctrl: RTL and testbench
===================================

# seq_capture_ctrl

Controller for the 16-bit capture register path. Watches a qualified serial bit stream for the pattern 1010 (MSB-first arrival order 1,0,1,0). On each detection it loads the 16-bit parallel input into the held output word and pulses a capture strobe. A detection counter and an optional post-capture lockout window are included. It sits between the serial control source and the downstream logic that consumes the held data word.

## Interface
- OVERLAP, 1: 1 = overlapping detection (after a hit, the trailing "10" is reused); 0 = the FSM restarts from IDLE after a hit.
- HOLD_CYCLES, 4: lockout length in clocks after a capture. Used only when the lockout macro is defined. Legal range 0..255.
- clk  in  1  single clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- serial_in  in  1  pattern bit; sampled only when serial_valid=1.
- serial_valid  in  1  bit qualifier; when 0, the FSM holds its state.
- clr_in  in  1  synchronous clear of FSM, counter and lockout; data_out is kept.
- data_in  in  16  parallel word to capture.
- data_out  out  16  held word; changes only on a capture edge.
- enable_out  out  1  registered one-cycle pulse, high the cycle after each capture.
- detect_count  out  8  saturating count of detections, including those suppressed by lockout.
- busy  out  1  high while lockout is active.

## Operation
- FSM states (Moore state, Mealy hit):
  - IDLE: 1→S1; 0→IDLE.
  - S1: 1→S1; 0→S10.
  - S10: 1→S101; 0→IDLE.
  - S101: 1→S1; 0→hit. On a hit, next state is S10 if OVERLAP=1, else IDLE.
- hit = serial_valid & (state==S101) & ~serial_in & ~clr_in.
- capture = hit & ~busy.
  - On the capture edge: data_out <= data_in, and enable_out <= 1 on the same edge.
  - Otherwise data_out holds and enable_out <= 0.
- detect_count increments on every hit and saturates at 8'hFF; it never wraps.
- Lockout:
  - On capture, the lockout counter loads HOLD_CYCLES and decrements by 1 per clock.
  - busy = (counter != 0).
  - With HOLD_CYCLES=0, busy never asserts.
  - A hit while busy is counted but does not capture and does not reload the counter.
- clr_in=1: state <= IDLE, detect_count <= 0, lockout counter <= 0, enable_out <= 0. clr_in has priority over a simultaneous hit, so no capture occurs on that edge.
- Reset values: data_out=16'h0000, enable_out=0, detect_count=0, busy=0, state=IDLE.

## Timing
- Latency: data_out reflects data_in one edge after the final 0 of the pattern is presented, i.e. the same edge that samples that bit.
- enable_out is high for exactly one cycle, aligned with the first cycle in which the new data_out is visible.
- Back-to-back captures with OVERLAP=1 and no lockout: minimum 2 valid bits apart ("101010" gives 2 hits).
- Stalls: serial_valid gaps of any length do not break a partial match.
- Reset mid-pattern discards the partial match immediately (asynchronous). Deassertion takes effect at the next rising edge.
- Lockout: busy rises the cycle after the capture edge and stays high for HOLD_CYCLES cycles.

## Configuration
- SEQ_CAPTURE_CTRL_LOCKOUT_EN defined: lockout counter and busy logic are present as described above.
- Not defined: no lockout counter; busy is tied to 0; every hit captures; HOLD_CYCLES is ignored.

## Structure
- Shared package seq_capture_pkg holds:
  - state enum typedef (IDLE, S1, S10, S101);
  - PATTERN_LEN=4;
  - DATA_W=16;
  - CNT_W=8.
- One sub-module: seq1010_fsm (pattern FSM, outputs hit). The top holds the capture register, counter and lockout.

## Test plan
- Reset: assert reset_n=0 mid-pattern with data_out=16'hBEEF → all outputs 0; after release, stream "1010" is needed from scratch.
- Basic hit: data_in=16'hA5A5, valid stream 1,0,1,0 → data_out=16'hA5A5 on the 4th-bit edge; enable_out one pulse; detect_count=1.
- Overlap: stream "1010100", OVERLAP=1 → 2 captures, count=2. With OVERLAP=0 → 1 capture, count=1.
- Stall: 1,0,(valid=0 for 5 cycles),1,0 → single capture; data_in changing during the stall → captures the value present on the final edge.
- Lockout (macro on, HOLD_CYCLES=4): "101010" → first hit captures, second is suppressed; busy high 4 cycles; count=2; data_out unchanged by the second hit.
- clr/saturation: clr_in together with the final 0 → no capture, count=0. Then 300 hits → count stays 8'hFF.

Source files
------------

// File: rtl/seq_capture_pkg.sv
// Shared types and widths for the seq_capture_ctrl slice: pattern FSM state
// encoding, data/counter widths and a saturating increment helper.
package seq_capture_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        S1   = 2'd1,
        S10  = 2'd2,
        S101 = 2'd3
    } state_t;

    localparam int PATTERN_LEN = 4;
    localparam int DATA_W      = 16;
    localparam int CNT_W       = 8;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == '1) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/seq1010_fsm.sv
// Pattern FSM for the serial sequence 1,0,1,0; Moore state, Mealy hit output.
// OVERLAP selects whether the trailing "10" of a hit seeds the next match.
module seq1010_fsm
    import seq_capture_pkg::*;
#(
    parameter int OVERLAP = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic serial_in,
    input  logic serial_valid,
    input  logic clr_in,
    output logic hit
);

    state_t state;
    state_t state_nxt;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt = state;
        if (clr_in) begin
            state_nxt = IDLE;
        end else if (serial_valid) begin
            case (state)
                IDLE:    state_nxt = serial_in ? S1   : IDLE;
                S1:      state_nxt = serial_in ? S1   : S10;
                S10:     state_nxt = serial_in ? S101 : IDLE;
                S101:    state_nxt = serial_in ? S1   : ((OVERLAP != 0) ? S10 : IDLE);
                default: state_nxt = IDLE;
            endcase
        end
    end

    // NOTE: registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    assign hit = serial_valid && (state == S101) && !serial_in && !clr_in;

endmodule

// File: rtl/seq_capture_ctrl.sv
// Capture controller: loads data_in into data_out on each 1010 detection,
// counts detections, and (with SEQ_CAPTURE_CTRL_LOCKOUT_EN) applies a post-capture lockout.
module seq_capture_ctrl
    import seq_capture_pkg::*;
#(
    parameter int OVERLAP     = 1,
    parameter int HOLD_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              serial_in,
    input  logic              serial_valid,
    input  logic              clr_in,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              enable_out,
    output logic [CNT_W-1:0]  detect_count,
    output logic              busy
);

    logic hit;
    logic capture;

    seq1010_fsm #(
        .OVERLAP (OVERLAP)
    ) u_fsm (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clr_in       (clr_in),
        .hit          (hit)
    );

    // hit already excludes clr_in, so a clear on the final bit never captures.
    assign capture = hit && !busy;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out     <= '0;
            enable_out   <= 1'b0;
            detect_count <= '0;
        end else begin
            enable_out <= capture;
            if (capture) begin
                data_out <= data_in;
            end
            if (clr_in) begin
                detect_count <= '0;
            end else if (hit) begin
                detect_count <= sat_inc(detect_count);
            end
        end
    end

`ifdef SEQ_CAPTURE_CTRL_LOCKOUT_EN
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);

    logic [CNT_W-1:0] hold_cnt;

    // Suppressed hits do not reload, so the window is measured from the capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
        end else if (clr_in) begin
            hold_cnt <= '0;
        end else if (capture) begin
            hold_cnt <= HOLD_LOAD;
        end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign busy = (hold_cnt != '0);
`else
    assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_seq_capture_ctrl.sv
// Bench for seq_capture_ctrl: one OVERLAP=1 and one OVERLAP=0 instance share stimulus;
// directed scenarios plus randomized traffic checked against a bit-history reference model.
module tb_seq_capture_ctrl;

    localparam int HOLD = 4;
`ifdef SEQ_CAPTURE_CTRL_LOCKOUT_EN
    localparam int HOLD_EFF = HOLD;
`else
    localparam int HOLD_EFF = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        serial_in;
    logic        serial_valid;
    logic        clr_in;
    logic [15:0] data_in;

    logic [15:0] obs_data [2];
    logic        obs_en   [2];
    logic [7:0]  obs_cnt  [2];
    logic        obs_busy [2];

    int checks   = 0;
    int failures = 0;

    // reference model state, index 0 = overlapping, 1 = non-overlapping
    int          win      [2];
    int          wlen     [2];
    logic [15:0] exp_data [2];
    logic        exp_en   [2];
    int          exp_cnt  [2];
    int          exp_hold [2];

    always #5 clk = ~clk;

    seq_capture_ctrl #(.OVERLAP(1), .HOLD_CYCLES(HOLD)) dut_ov (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clr_in       (clr_in),
        .data_in      (data_in),
        .data_out     (obs_data[0]),
        .enable_out   (obs_en[0]),
        .detect_count (obs_cnt[0]),
        .busy         (obs_busy[0])
    );

    seq_capture_ctrl #(.OVERLAP(0), .HOLD_CYCLES(HOLD)) dut_nov (
        .clk          (clk),
        .reset_n      (reset_n),
        .serial_in    (serial_in),
        .serial_valid (serial_valid),
        .clr_in       (clr_in),
        .data_in      (data_in),
        .data_out     (obs_data[1]),
        .enable_out   (obs_en[1]),
        .detect_count (obs_cnt[1]),
        .busy         (obs_busy[1])
    );

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            win[i] = 0; wlen[i] = 0; exp_data[i] = 16'h0000;
            exp_en[i] = 1'b0; exp_cnt[i] = 0; exp_hold[i] = 0;
        end
    endtask

    // One clock edge of the spec behaviour: hit = last four valid bits since restart are 1,0,1,0.
    task automatic model_edge(input bit v, input bit b, input bit c, input logic [15:0] d);
        bit hit;
        bit cap;
        for (int i = 0; i < 2; i++) begin
            if (c) begin
                win[i] = 0; wlen[i] = 0; exp_cnt[i] = 0; exp_hold[i] = 0; exp_en[i] = 1'b0;
            end else begin
                hit = 1'b0;
                if (v) begin
                    win[i] = ((win[i] << 1) | int'(b)) & 15;
                    if (wlen[i] < 4) wlen[i]++;
                    hit = (wlen[i] == 4) && (win[i] == 4'b1010);
                end
                cap = hit && (exp_hold[i] == 0);
                if (cap) exp_hold[i] = HOLD_EFF;
                else if (exp_hold[i] > 0) exp_hold[i]--;
                exp_en[i] = cap;
                if (cap) exp_data[i] = d;
                if (hit && exp_cnt[i] < 255) exp_cnt[i]++;
                if (hit && i == 1) begin
                    win[i] = 0; wlen[i] = 0;
                end
            end
        end
    endtask

    task automatic step(input bit v, input bit b, input bit c, input logic [15:0] d);
        serial_valid = v; serial_in = b; clr_in = c; data_in = d;
        @(posedge clk);
        model_edge(v, b, c, d);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; serial_valid = 1'b0; serial_in = 1'b0; clr_in = 1'b0; data_in = 16'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_data[i] !== 16'h0 || obs_en[i] !== 1'b0 || obs_cnt[i] !== 8'h0 || obs_busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_init[%0d]: data=%h en=%b cnt=%0d busy=%b, expected all zero",
                         i, obs_data[i], obs_en[i], obs_cnt[i], obs_busy[i]);
            end
        end
        reset_n = 1'b1;
        step(1, 1, 0, 16'hBEEF); step(1, 0, 0, 16'hBEEF);
        step(1, 1, 0, 16'hBEEF); step(1, 0, 0, 16'hBEEF);
        checks++;
        if (obs_data[0] !== 16'hBEEF) begin
            failures++;
            $display("FAIL reset_preload: data=%h expected beef", obs_data[0]);
        end
        step(1, 1, 0, 16'hBEEF); step(1, 0, 0, 16'hBEEF);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_data[i] !== 16'h0 || obs_en[i] !== 1'b0 || obs_cnt[i] !== 8'h0 || obs_busy[i] !== 1'b0) begin
                failures++;
                $display("FAIL reset_async[%0d]: data=%h en=%b cnt=%0d busy=%b, expected all zero",
                         i, obs_data[i], obs_en[i], obs_cnt[i], obs_busy[i]);
            end
        end
        #2 reset_n = 1'b1;
        step(1, 1, 0, 16'h1234); step(1, 0, 0, 16'h1234);
        checks++;
        if (obs_cnt[0] !== 8'd0 || obs_data[0] !== 16'h0) begin
            failures++;
            $display("FAIL reset_partial_discard: cnt=%0d data=%h expected 0/0000", obs_cnt[0], obs_data[0]);
        end
        step(1, 1, 0, 16'h1234); step(1, 0, 0, 16'h1234);
        checks++;
        if (obs_cnt[0] !== 8'd1 || obs_data[0] !== 16'h1234) begin
            failures++;
            $display("FAIL reset_fresh_hit: cnt=%0d data=%h expected 1/1234", obs_cnt[0], obs_data[0]);
        end
    endtask

    task automatic test_basic();
        step(0, 0, 1, 16'h0);
        step(1, 1, 0, 16'hA5A5); step(1, 0, 0, 16'hA5A5); step(1, 1, 0, 16'hA5A5);
        checks++;
        if (obs_en[0] !== 1'b0 || obs_data[0] !== 16'h1234) begin
            failures++;
            $display("FAIL basic_early: en=%b data=%h expected 0/1234", obs_en[0], obs_data[0]);
        end
        step(1, 0, 0, 16'hA5A5);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_data[i] !== 16'hA5A5 || obs_en[i] !== 1'b1 || obs_cnt[i] !== 8'd1) begin
                failures++;
                $display("FAIL basic_hit[%0d]: data=%h en=%b cnt=%0d expected a5a5/1/1",
                         i, obs_data[i], obs_en[i], obs_cnt[i]);
            end
        end
        step(0, 0, 0, 16'h5555);
        checks++;
        if (obs_en[0] !== 1'b0 || obs_data[0] !== 16'hA5A5) begin
            failures++;
            $display("FAIL basic_pulse_end: en=%b data=%h expected 0/a5a5", obs_en[0], obs_data[0]);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] bits = 7'b1010100;
        int caps [2] = '{0, 0};
        int exp_caps_ov = (HOLD_EFF > 1) ? 1 : 2;
        step(0, 0, 1, 16'h0);
        for (int k = 6; k >= 0; k--) begin
            step(1, bits[k], 0, 16'h0100 + 16'(k));
            for (int i = 0; i < 2; i++) caps[i] += int'(obs_en[i]);
        end
        checks++;
        if (obs_cnt[0] !== 8'd2 || caps[0] != exp_caps_ov) begin
            failures++;
            $display("FAIL overlap_on: cnt=%0d caps=%0d expected 2/%0d", obs_cnt[0], caps[0], exp_caps_ov);
        end
        checks++;
        if (obs_cnt[1] !== 8'd1 || caps[1] != 1) begin
            failures++;
            $display("FAIL overlap_off: cnt=%0d caps=%0d expected 1/1", obs_cnt[1], caps[1]);
        end
    endtask

    task automatic test_stall();
        int early = 0;
        step(0, 0, 1, 16'h0);
        step(1, 1, 0, 16'h0001); step(1, 0, 0, 16'h0002);
        repeat (5) begin
            step(0, 1'($urandom), 0, 16'($urandom));
            early += int'(obs_en[0]) + int'(obs_en[1]);
        end
        step(1, 1, 0, 16'h1111);
        early += int'(obs_en[0]) + int'(obs_en[1]);
        checks++;
        if (early != 0) begin
            failures++;
            $display("FAIL stall_early: pulses=%0d expected 0", early);
        end
        step(1, 0, 0, 16'hCAFE);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_data[i] !== 16'hCAFE || obs_en[i] !== 1'b1 || obs_cnt[i] !== 8'd1) begin
                failures++;
                $display("FAIL stall_hit[%0d]: data=%h en=%b cnt=%0d expected cafe/1/1",
                         i, obs_data[i], obs_en[i], obs_cnt[i]);
            end
        end
    endtask

    task automatic test_clr_saturation();
        step(0, 0, 1, 16'h0);
        step(1, 1, 0, 16'h0001); step(1, 0, 0, 16'h0002); step(1, 1, 0, 16'h0003);
        step(1, 0, 1, 16'hDEAD);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_data[i] !== 16'hCAFE || obs_en[i] !== 1'b0 || obs_cnt[i] !== 8'd0) begin
                failures++;
                $display("FAIL clr_priority[%0d]: data=%h en=%b cnt=%0d expected cafe/0/0",
                         i, obs_data[i], obs_en[i], obs_cnt[i]);
            end
        end
        step(1, 1, 0, 16'h0004); step(1, 0, 0, 16'h0005);
        checks++;
        if (obs_cnt[0] !== 8'd0) begin
            failures++;
            $display("FAIL clr_state: cnt=%0d expected 0", obs_cnt[0]);
        end
        for (int rep = 1; rep <= 300; rep++) begin
            step(1, 1, 0, 16'(rep)); step(1, 0, 0, 16'(rep));
            step(1, 1, 0, 16'(rep)); step(1, 0, 0, 16'(rep));
            if (rep == 254) begin
                checks++;
                if (obs_cnt[1] !== 8'd254) begin
                    failures++;
                    $display("FAIL sat_before: cnt=%0d expected 254", obs_cnt[1]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (obs_cnt[i] !== 8'hFF) begin
                failures++;
                $display("FAIL sat_hold[%0d]: cnt=%0d expected 255", i, obs_cnt[i]);
            end
        end
    endtask

    task automatic test_lockout();
        logic [5:0] bits = 6'b101010;
        int caps = 0;
        int busy_cycles = 0;
        step(0, 0, 1, 16'h0);
        for (int k = 0; k < 12; k++) begin
            if (k < 6) step(1, bits[5-k], 0, 16'h1000 + 16'(k));
            else       step(0, 0, 0, 16'h2000 + 16'(k));
            caps += int'(obs_en[0]);
            busy_cycles += int'(obs_busy[0]);
        end
        checks++;
        if (caps != ((HOLD_EFF > 1) ? 1 : 2) || obs_cnt[0] !== 8'd2) begin
            failures++;
            $display("FAIL lockout_caps: caps=%0d cnt=%0d expected %0d/2",
                     caps, obs_cnt[0], (HOLD_EFF > 1) ? 1 : 2);
        end
        checks++;
        if (busy_cycles != HOLD_EFF) begin
            failures++;
            $display("FAIL lockout_busy_len: busy_cycles=%0d expected %0d", busy_cycles, HOLD_EFF);
        end
        checks++;
        if (obs_data[0] !== ((HOLD_EFF > 1) ? 16'h1003 : 16'h1005)) begin
            failures++;
            $display("FAIL lockout_data: data=%h expected %h",
                     obs_data[0], (HOLD_EFF > 1) ? 16'h1003 : 16'h1005);
        end
    endtask

    task automatic test_random();
        step(0, 0, 1, 16'h0);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            step(($urandom % 4) != 0, 1'($urandom), ($urandom % 64) == 0, 16'($urandom));
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (obs_data[i] !== exp_data[i] || obs_en[i] !== exp_en[i] ||
                    obs_cnt[i] !== 8'(exp_cnt[i]) || obs_busy[i] !== (exp_hold[i] != 0)) begin
                    failures++;
                    $display("FAIL random[%0d] cycle %0d: data=%h en=%b cnt=%0d busy=%b expected %h/%b/%0d/%b",
                             i, cyc, obs_data[i], obs_en[i], obs_cnt[i], obs_busy[i],
                             exp_data[i], exp_en[i], exp_cnt[i], exp_hold[i] != 0);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_stall();
        test_clr_saturation();
        test_lockout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
